// File: rtl/contador_pkg.sv
// contador_pkg: shared types and helpers for the counter controller.
// Optional feature macro: CONTADOR_UPDOWN_EN (adds down-counting, see top).
package contador_pkg;

   // Default counter width and default terminal value.
   localparam int DEF_W       = 4;
   localparam int DEF_LIM_VAL = 9;

   // Controller state encoding, also exported on the debug port.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   // Terminal value from the requested limit: a zero request means the
   // full w-bit range (all ones). Only the low w bits are meaningful.
   function automatic logic [31:0] lim_of(input logic [31:0] l, input int unsigned w);
      logic [31:0] full;
      full = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      if ((l & full) == 32'd0) begin
         return full;
      end
      return l & full;
   endfunction

endpackage

// File: rtl/contador_if.sv
// contador_if: control/status bundle between the sequencing logic and the
// counter controller. The master drives the requests (S, P, M, L and, with
// CONTADOR_UPDOWN_EN, D); the slave returns the count and the flags.
// Handshake: there is no valid/ready pair; S and P are level requests that
// the controller samples on every falling clock edge, and every status
// output is a register updated on that same edge.
interface contador_if import contador_pkg::*; #(parameter int W = DEF_W) ();

   logic         S;
   logic         P;
   logic         M;
   logic [W-1:0] L;
`ifdef CONTADOR_UPDOWN_EN
   logic         D;
`endif
   logic [W-1:0] O;
   logic         BUSY;
   logic         TC;
   logic         FIN;

`ifdef CONTADOR_UPDOWN_EN
   modport master (output S, P, M, L, D, input O, BUSY, TC, FIN);
   modport slave  (input S, P, M, L, D, output O, BUSY, TC, FIN);
`else
   modport master (output S, P, M, L, input O, BUSY, TC, FIN);
   modport slave  (input S, P, M, L, output O, BUSY, TC, FIN);
`endif

endinterface

// File: rtl/contador_datapath.sv
// contador_datapath: W-bit count register with clear, load and enable,
// counting up (or down under CONTADOR_UPDOWN_EN), plus the terminal compares.
// Priority inside the register: clear > load > enable.
module contador_datapath import contador_pkg::*; #(
   parameter int W = DEF_W
) (
   input  logic         C,
   input  logic         nR,
   input  logic         clr,
   input  logic         load,
   input  logic         en,
`ifdef CONTADOR_UPDOWN_EN
   input  logic         dn,
`endif
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] lim,
`ifdef CONTADOR_UPDOWN_EN
   output logic         at_zero,
`endif
   output logic [W-1:0] cnt,
   output logic         at_lim
);

   localparam logic [W-1:0] ONE = W'(1);

   // Count register, updated on the falling clock edge; wraps modulo 2^W.
   always_ff @(negedge C or negedge nR) begin
      if (!nR) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
`ifdef CONTADOR_UPDOWN_EN
         cnt <= dn ? (cnt - ONE) : (cnt + ONE);
`else
         cnt <= cnt + ONE;
`endif
      end
   end

   // Exact W-bit compares used as terminal conditions.
   assign at_lim  = (cnt == lim);
`ifdef CONTADOR_UPDOWN_EN
   assign at_zero = (cnt == '0);
`endif

endmodule

// File: rtl/controlador_contador.sv
// controlador_contador: start/pause/resume/stop sequencing for the counter
// datapath, with a terminal value latched on each accepted start, one-shot
// or continuous mode, a one-cycle TC pulse on wrap and a FIN flag in DONE.
// Optional macro CONTADOR_UPDOWN_EN: direction D is latched with L on start;
// D=1 loads the terminal value and counts down to zero.
// All state changes on the falling edge of C; reset nR is async active-low.
module controlador_contador import contador_pkg::*; #(
   parameter int W       = DEF_W,
   parameter int DEF_LIM = DEF_LIM_VAL
) (
   input  logic       C,
   input  logic       nR,
   contador_if.slave  bus,
   output state_t     dbg_state
);

   state_t       state;
   state_t       state_n;
   logic [W-1:0] lim;
   logic [W-1:0] lim_d;
   logic [W-1:0] cnt;
   logic [W-1:0] load_val;
   logic         at_lim;
   logic         term;
   logic         clr;
   logic         load;
   logic         en;
   logic         tc_n;
   logic         latch;
   logic         tc_q;
   logic         busy_q;
   logic         fin_q;
`ifdef CONTADOR_UPDOWN_EN
   logic         dir;
   logic         at_zero;
`endif

   // Terminal value that an accepted start would latch.
   assign lim_d = W'(lim_of(32'(bus.L), W));

`ifdef CONTADOR_UPDOWN_EN
   assign term = dir ? at_zero : at_lim;
`else
   assign term = at_lim;
`endif

   contador_datapath #(.W(W)) u_datapath (
      .C        (C),
      .nR       (nR),
      .clr      (clr),
      .load     (load),
      .en       (en),
`ifdef CONTADOR_UPDOWN_EN
      .dn       (dir),
      .at_zero  (at_zero),
`endif
      .load_val (load_val),
      .lim      (lim),
      .cnt      (cnt),
      .at_lim   (at_lim)
   );

   // State register.
   always_ff @(negedge C or negedge nR) begin
      if (!nR) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state: in RUN a pause beats the terminal wrap, which beats counting.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (bus.S) state_n = RUN;
         RUN: begin
            if (bus.P) begin
               state_n = PAUSE;
            end else if (term) begin
               state_n = bus.M ? RUN : DONE;
            end
         end
         PAUSE:   if (bus.S && !bus.P) state_n = RUN;
         DONE:    if (bus.S) state_n = RUN;
         default: state_n = IDLE;
      endcase
   end

   // Datapath controls and next-cycle flag values for the current state.
   always_comb begin
      clr      = 1'b0;
      load     = 1'b0;
      en       = 1'b0;
      tc_n     = 1'b0;
      latch    = 1'b0;
      load_val = lim;
      case (state)
         IDLE, DONE: begin
            // Count rests at zero; the start edge itself does not count.
            clr = 1'b1;
            if (bus.S) begin
               latch = 1'b1;
`ifdef CONTADOR_UPDOWN_EN
               if (bus.D) begin
                  clr      = 1'b0;
                  load     = 1'b1;
                  load_val = lim_d;
               end
`endif
            end
         end
         RUN: begin
            if (!bus.P) begin
               if (term) begin
                  tc_n = 1'b1;
                  clr  = 1'b1;
`ifdef CONTADOR_UPDOWN_EN
                  // Continuous down-count restarts from the terminal value;
                  // a one-shot finish always parks the count at zero.
                  if (dir && bus.M) begin
                     clr  = 1'b0;
                     load = 1'b1;
                  end
`endif
               end else begin
                  en = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Registered flags plus the limit/direction latches, taken on starts only.
   always_ff @(negedge C or negedge nR) begin
      if (!nR) begin
         tc_q   <= 1'b0;
         busy_q <= 1'b0;
         fin_q  <= 1'b0;
         lim    <= W'(DEF_LIM);
`ifdef CONTADOR_UPDOWN_EN
         dir    <= 1'b0;
`endif
      end else begin
         tc_q   <= tc_n;
         busy_q <= (state_n == RUN) || (state_n == PAUSE);
         fin_q  <= (state_n == DONE);
         if (latch) begin
            lim <= lim_d;
`ifdef CONTADOR_UPDOWN_EN
            dir <= bus.D;
`endif
         end
      end
   end

   assign bus.O     = cnt;
   assign bus.BUSY  = busy_q;
   assign bus.TC    = tc_q;
   assign bus.FIN   = fin_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_controlador_contador.sv
// tb_controlador_contador: directed sequence against controlador_contador.
// Inputs change on the rising edge of C, the DUT acts on the falling edge,
// and outputs are compared on the following rising edge.
module tb_controlador_contador;
   import contador_pkg::*;

   localparam int W = 4;

   logic   C = 1'b1;
   logic   nR;
   state_t dbg_state;

   contador_if #(.W(W)) bus ();

   controlador_contador #(.W(W), .DEF_LIM(9)) dut (
      .C         (C),
      .nR        (nR),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock: period 10, falling edges at 5, 15, 25, ...
   always #5 C = ~C;

   int checks = 0;
   int errors = 0;
   logic [W+2:0] exp_q[$];

   task automatic cmp(input string tag, input logic [W+2:0] obs, input logic [W+2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h ({O,BUSY,TC,FIN})", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the outputs expected after the next
   // falling edge, then pop and compare at the following rising edge.
   task automatic step(input logic s, input logic p, input logic m, input logic [W-1:0] l,
                       input logic [W-1:0] o, input logic busy, input logic tc,
                       input logic fin, input string tag);
      logic [W+2:0] exp;
      bus.S = s;
      bus.P = p;
      bus.M = m;
      bus.L = l;
      exp_q.push_back({o, busy, tc, fin});
      @(posedge C);
      if (exp_q.size() == 0) begin
         exp = '1;
      end else begin
         exp = exp_q.pop_front();
      end
      cmp(tag, {bus.O, bus.BUSY, bus.TC, bus.FIN}, exp);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      nR    = 1'b0;
      bus.S = 1'b0;
      bus.P = 1'b0;
      bus.M = 1'b0;
      bus.L = '0;
`ifdef CONTADOR_UPDOWN_EN
      bus.D = 1'b0;
`endif

      // Reset state (after the first falling edge under reset).
      #7;
      cmp("reset_out", {bus.O, bus.BUSY, bus.TC, bus.FIN}, '0);
      cmp("reset_state", 7'(dbg_state), 7'(IDLE));
      @(posedge C);
      @(posedge C);
      nR = 1'b1;

      // One-shot, L=5: 0,1,2,3,4,5,0 then DONE; TC one cycle after 5->0.
      step(1, 0, 0, 5, 0, 1, 0, 0, "os_start");
      for (int k = 1; k <= 5; k++) step(0, 0, 0, 5, W'(k), 1, 0, 0, "os_count");
      step(0, 0, 0, 5, 0, 0, 1, 1, "os_wrap");
      step(0, 0, 0, 5, 0, 0, 0, 1, "os_done1");
      step(0, 0, 0, 5, 0, 0, 0, 1, "os_done2");

      // Continuous, L=3: 0,1,2,3 repeating, TC every 4th cycle, FIN stays 0.
      step(1, 0, 1, 3, 0, 1, 0, 0, "cont_start");
      for (int k = 1; k <= 20; k++) step(0, 0, 1, 3, W'(k % 4), 1, (k % 4 == 0), 0, "cont");

      // S during RUN is ignored (no restart, no new limit); then finish one-shot.
      step(1, 0, 0, 9, 1, 1, 0, 0, "run_s_ignored");
      step(0, 0, 0, 9, 2, 1, 0, 0, "run_keep_lim");
      step(0, 0, 0, 9, 3, 1, 0, 0, "run_keep_lim");
      step(0, 0, 0, 9, 0, 0, 1, 1, "old_lim_wrap");

      // Pause/resume with L=9.
      step(1, 0, 0, 9, 0, 1, 0, 0, "pr_start");
      for (int k = 1; k <= 4; k++) step(0, 0, 0, 9, W'(k), 1, 0, 0, "pr_count");
      for (int k = 0; k < 3; k++) step(0, 1, 0, 9, 4, 1, 0, 0, "pause_hold");
      step(1, 1, 0, 9, 4, 1, 0, 0, "s_with_p");
      step(0, 0, 0, 9, 4, 1, 0, 0, "p_release_only");
      step(1, 0, 0, 9, 4, 1, 0, 0, "resume_edge");
      step(0, 0, 0, 9, 5, 1, 0, 0, "resume_next");
      step(0, 0, 0, 9, 6, 1, 0, 0, "resume_6");
      step(0, 0, 0, 9, 7, 1, 0, 0, "resume_7");

      // Asynchronous reset mid-cycle while RUN at O=7.
      #2;
      nR = 1'b0;
      #1;
      cmp("midrst_out", {bus.O, bus.BUSY, bus.TC, bus.FIN}, '0);
      cmp("midrst_state", 7'(dbg_state), 7'(IDLE));
      @(posedge C);
      nR = 1'b1;

      // L=0 means full range 0..15; changing L mid-run has no effect.
      step(1, 0, 0, 0, 0, 1, 0, 0, "full_start");
      for (int k = 1; k <= 15; k++) step(0, 0, 0, (k >= 3) ? 4'd2 : 4'd0, W'(k), 1, 0, 0, "full");
      step(0, 0, 0, 2, 0, 0, 1, 1, "full_wrap");
      step(0, 0, 0, 2, 0, 0, 0, 1, "full_done");

      // The new L=2 takes effect at the next start from DONE.
      step(1, 0, 0, 2, 0, 1, 0, 0, "newlim_start");
      step(0, 0, 0, 2, 1, 1, 0, 0, "newlim_1");
      step(0, 0, 0, 2, 2, 1, 0, 0, "newlim_2");
      step(0, 0, 0, 2, 0, 0, 1, 1, "newlim_wrap");
      step(0, 0, 0, 2, 0, 0, 0, 1, "newlim_done");

`ifdef CONTADOR_UPDOWN_EN
      // Down-count one-shot, L=4: 4,3,2,1,0 then wrap into DONE with O=0.
      bus.D = 1'b1;
      step(1, 0, 0, 4, 4, 1, 0, 0, "dn_start");
      for (int k = 3; k >= 0; k--) step(0, 0, 0, 4, W'(k), 1, 0, 0, "dn_count");
      step(0, 0, 0, 4, 0, 0, 1, 1, "dn_wrap");
      step(0, 0, 0, 4, 0, 0, 0, 1, "dn_done");
      bus.D = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
